// File: rtl/caja_pkg.sv
// Shared constants for the music-box key arbiter: key count, note indices,
// half-period table (50 MHz clock, value = 50e6 / (2 * f)) and FSM states.
package caja_pkg;

  localparam int NUM_TECLAS = 7;

  localparam logic [2:0] DO  = 3'd0;
  localparam logic [2:0] RE  = 3'd1;
  localparam logic [2:0] MI  = 3'd2;
  localparam logic [2:0] FA  = 3'd3;
  localparam logic [2:0] SOL = 3'd4;
  localparam logic [2:0] LA  = 3'd5;
  localparam logic [2:0] SI  = 3'd6;

  localparam logic [16:0] TABLA_SEMIPERIODO [NUM_TECLAS] = '{
    17'd95556, 17'd85131, 17'd75843, 17'd71586,
    17'd63776, 17'd56818, 17'd50619
  };

  typedef enum logic [1:0] {
    SILENCIO  = 2'd0,
    SONANDO   = 2'd1,
    SOSTENIDO = 2'd2
  } estado_t;

  // Lowest pressed key wins; returns DO for an empty vector.
  function automatic logic [2:0] tecla_menor(input logic [NUM_TECLAS-1:0] v);
    tecla_menor = DO;
    for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
      if (v[i]) tecla_menor = 3'(i);
    end
  endfunction

  // Index 7 cannot occur in practice; it maps to silence rather than garbage.
  function automatic logic [16:0] semiperiodo_de(input logic [2:0] idx);
    semiperiodo_de = (idx < 3'(NUM_TECLAS)) ? TABLA_SEMIPERIODO[idx] : 17'd0;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Key synchroniser and whole-vector debouncer. The vector is accepted once
// the synchronised keys have been identical for DEB_CICLOS consecutive cycles;
// actualiza pulses for one cycle in the cycle the new vector appears.
module antirrebote
  import caja_pkg::*;
#(
  parameter int DEB_CICLOS = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TECLAS-1:0] teclas,
  output logic [NUM_TECLAS-1:0] teclas_estables,
  output logic                  actualiza
);

  localparam int CNT_W = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN   = CNT_W'(DEB_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(DEB_CICLOS - 2);

  logic [NUM_TECLAS-1:0] sinc_1, sinc_2, previo;
  logic [CNT_W-1:0]      cnt;

  // Two-flop synchroniser for the asynchronous keys.
  always_ff @(posedge clk) begin
    if (reset) begin
      sinc_1 <= '0;
      sinc_2 <= '0;
    end else begin
      sinc_1 <= teclas;
      sinc_2 <= sinc_1;
    end
  end

  // Stability counter: restarts on any change, loads the vector in the same
  // edge it reaches the terminal count, then saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      previo          <= '0;
      cnt             <= '0;
      teclas_estables <= '0;
      actualiza       <= 1'b0;
    end else begin
      previo    <= sinc_2;
      actualiza <= 1'b0;
      if (sinc_2 != previo) begin
        cnt <= '0;
      end else if (cnt != CNT_FIN) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_CARGA) begin
          teclas_estables <= sinc_2;
          actualiza       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arbitro_teclas.sv
// Key arbiter and note scheduler for the music-box tone generator.
// Optional release sustain is compiled in with the macro SOSTENIDO_EN.
//
// state     | meaning
// SILENCIO  | no note output; waits for a stable key with habilitar=1
// SONANDO   | note nota_idx sounding; held while its key stays pressed
// SOSTENIDO | keys released, note kept for SUSTAIN_CICLOS (SOSTENIDO_EN only)
module arbitro_teclas
  import caja_pkg::*;
#(
  parameter int DEB_CICLOS     = 1000000,
  parameter int SUSTAIN_CICLOS = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TECLAS-1:0] teclas,
  input  logic                  habilitar,
  output logic [NUM_TECLAS-1:0] teclas_estables,
  output logic [2:0]            nota_idx,
  output logic [16:0]           semiperiodo,
  output logic                  sonando,
  output logic                  cambio
);

  logic [NUM_TECLAS-1:0] estables;
  logic                  actualiza;
  estado_t               estado, estado_n;
  logic [2:0]            nota_n;
  logic                  sonando_n;
  logic [16:0]           semi_n;
  logic                  cambio_n;
  logic                  reanuda;

  antirrebote #(
    .DEB_CICLOS(DEB_CICLOS)
  ) u_antirrebote (
    .clk            (clk),
    .reset          (reset),
    .teclas         (teclas),
    .teclas_estables(estables),
    .actualiza      (actualiza)
  );

  assign teclas_estables = estables;

`ifdef SOSTENIDO_EN
  localparam int SUS_W = (SUSTAIN_CICLOS > 1) ? $clog2(SUSTAIN_CICLOS) : 1;
  localparam logic [SUS_W-1:0] SUS_FIN = SUS_W'(SUSTAIN_CICLOS - 1);

  logic [SUS_W-1:0] sus_cnt, sus_cnt_n;

  // Sustain timer, only meaningful while in SOSTENIDO.
  always_ff @(posedge clk) begin
    if (reset) sus_cnt <= '0;
    else       sus_cnt <= sus_cnt_n;
  end
`else
  // The parameter stays on the interface so both builds share one port map.
  logic sustain_unused;
  assign sustain_unused = (SUSTAIN_CICLOS > 0);
`endif

  // Next state and next registered outputs.
  always_comb begin
    estado_n  = estado;
    nota_n    = nota_idx;
    sonando_n = sonando;
    semi_n    = semiperiodo;
    reanuda   = 1'b0;
`ifdef SOSTENIDO_EN
    sus_cnt_n = sus_cnt;
`endif
    if (!habilitar) begin
      estado_n  = SILENCIO;
      sonando_n = 1'b0;
      semi_n    = '0;
`ifdef SOSTENIDO_EN
      sus_cnt_n = '0;
`endif
    end else begin
      case (estado)
        SILENCIO: begin
          if (|estables) begin
            estado_n  = SONANDO;
            nota_n    = tecla_menor(estables);
            sonando_n = 1'b1;
            semi_n    = semiperiodo_de(nota_n);
          end
        end
        SONANDO: begin
          // The held note is only re-evaluated when the stable vector moves.
          if (actualiza && !estables[nota_idx]) begin
            if (|estables) begin
              nota_n = tecla_menor(estables);
              semi_n = semiperiodo_de(nota_n);
            end else begin
`ifdef SOSTENIDO_EN
              estado_n  = SOSTENIDO;
              sus_cnt_n = '0;
`else
              estado_n  = SILENCIO;
              sonando_n = 1'b0;
              semi_n    = '0;
`endif
            end
          end
        end
`ifdef SOSTENIDO_EN
        SOSTENIDO: begin
          if (|estables) begin
            estado_n  = SONANDO;
            nota_n    = tecla_menor(estables);
            sonando_n = 1'b1;
            semi_n    = semiperiodo_de(nota_n);
            sus_cnt_n = '0;
            reanuda   = 1'b1;
          end else if (sus_cnt == SUS_FIN) begin
            estado_n  = SILENCIO;
            sonando_n = 1'b0;
            semi_n    = '0;
          end else begin
            sus_cnt_n = sus_cnt + 1'b1;
          end
        end
`endif
        default: estado_n = SILENCIO;
      endcase
    end
    // A re-press during sustain pulses cambio even if the note is the same.
    cambio_n = (nota_n != nota_idx) || (sonando_n != sonando) || reanuda;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= SILENCIO;
      nota_idx    <= DO;
      semiperiodo <= '0;
      sonando     <= 1'b0;
      cambio      <= 1'b0;
    end else begin
      estado      <= estado_n;
      nota_idx    <= nota_n;
      semiperiodo <= semi_n;
      sonando     <= sonando_n;
      cambio      <= cambio_n;
    end
  end

endmodule

// File: doc/arbitro_teclas.md
Name: arbitro_teclas

Overview:
Key arbiter and note scheduler for the music-box tone generator. It synchronises and debounces the 7 raw keys, then picks one note when several keys are held. It drives the generator's half-period count plus a sounding flag, and sits between the board keys and the tone datapath that produces clk_out. System clock is 50 MHz.

Parameters:
DEB_CICLOS, 1000000, cycles the synchronised key vector must stay unchanged before it is accepted (20 ms).
SUSTAIN_CICLOS, 5000000, cycles a released note keeps sounding; used only with SOSTENIDO_EN (100 ms).

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
teclas  input  7  raw asynchronous keys; bit0=Do … bit6=Si; 1=pressed
habilitar  input  1  1=normal operation; 0=force silence
teclas_estables  output  7  debounced key vector
nota_idx  output  3  index 0..6 of the note being played
semiperiodo  output  17  half-period count in clk cycles for the tone generator; 0 when silent
sonando  output  1  1 while a note is output
cambio  output  1  one-cycle pulse when nota_idx or sonando changes

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset clears everything to 0: sync flops, debounce counter, teclas_estables, nota_idx, semiperiodo, sonando, cambio. State goes to SILENCIO.
- Synchroniser: 2 flops per key bit.
- Debounce works on the whole vector:
  - The counter clears whenever the synced vector differs from its previous value.
  - When the counter reaches DEB_CICLOS-1 with the vector unchanged, teclas_estables takes the synced vector. The counter saturates there.
  - Counter width is clog2(DEB_CICLOS).
- Half-period table, indexed by nota_idx (value = 50e6/(2f)): 0:95556, 1:85131, 2:75843, 3:71586, 4:63776, 5:56818, 6:50619.
- FSM state SILENCIO: when habilitar=1 and teclas_estables≠0, pick the lowest set index and go to SONANDO.
- FSM state SONANDO: this is a no-preemption rule.
  - While bit nota_idx of teclas_estables stays 1, the note holds, whatever other keys do.
  - When that bit drops and other keys are held, switch to the lowest remaining index in the same cycle.
  - When that bit drops and no keys are held, go to SILENCIO (or SOSTENIDO when SOSTENIDO_EN is defined).
- habilitar=0 in any state: next cycle goes to SILENCIO with sonando=0 and semiperiodo=0; nota_idx keeps its last value. On re-assert, arbitration resumes the cycle after.
- Outputs are registered, one cycle after the teclas_estables update. Raw-key-to-output latency is 2 + DEB_CICLOS + 1 cycles.
- cambio is registered and asserts in the same cycle the changed outputs appear.
- Simultaneous press of several keys from silence: lowest index wins.
- Release and press landing in the same debounce update: rule is evaluated on the new vector only.

Optional Feature:
SOSTENIDO_EN
- Defined: adds state SOSTENIDO and a SUSTAIN_CICLOS counter.
  - On release to an empty vector, the note keeps sounding, with sonando=1 and the same semiperiodo, for exactly SUSTAIN_CICLOS cycles. Then the block goes to SILENCIO with a cambio pulse.
  - A new stable press during SOSTENIDO goes straight to SONANDO with the lowest index; the counter clears and cambio pulses.
  - habilitar=0 aborts SOSTENIDO.
- Undefined: no counter and no state; release goes straight to SILENCIO.

Decomposition:
- Package caja_pkg holds:
  - NUM_TECLAS=7;
  - note index constants DO..SI;
  - the 7-entry half-period constant table, 17-bit;
  - the FSM state enum: SILENCIO, SONANDO, SOSTENIDO.
- Sub-module antirrebote holds the 2-flop synchroniser and the vector debounce counter. It outputs teclas_estables plus a one-cycle update strobe.

Test Plan:
(Simulation uses DEB_CICLOS=4, SUSTAIN_CICLOS=10, and a 20 ns clock.)
1. Reset asserted 3 cycles, teclas=0 -> all outputs 0; cambio never pulses.
2. teclas=7'b0000100 held -> 7 cycles later: sonando=1, nota_idx=2, semiperiodo=75843, cambio high for exactly 1 cycle.
3. teclas bit0 high for 3 cycles then low -> teclas_estables stays 0; no output change.
4. Note 2 playing, add bit0 -> note 2 holds. Drop bit2 -> nota_idx=0, semiperiodo=95556, one cambio pulse.
5. Note 5 playing, habilitar=0 -> next cycle sonando=0, semiperiodo=0, cambio pulse. habilitar=1 -> sonando=1, semiperiodo=56818 the cycle after.
6. Sustain:
   - With SOSTENIDO_EN, release all keys -> sonando stays 1 for 10 cycles, then 0.
   - Repeat and press bit6 during sustain -> nota_idx=6, semiperiodo=50619 immediately.
   - Without SOSTENIDO_EN -> sonando=0 one cycle after the teclas_estables update.
